// File: rtl/uart_rx_os_if.sv
// Receive-side bus of the oversampled UART receiver: serial line, tick, ack and
// the registered byte/status outputs.
interface uart_rx_os_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic                 rxd;
  logic                 rx_int;
  logic                 rx_ack;
  logic [DATA_BITS-1:0] rxdata;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rxd, rx_int, rx_ack,
    input  rxdata, rx_valid, frame_err, overrun
  );

  modport slave (
    input  rxd, rx_int, rx_ack,
    output rxdata, rx_valid, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_os.sv
// UART 8N1-style receiver sampling the line on an external oversample tick, with
// valid/ack hand-off plus framing and overrun status.
module uart_rx_os #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic         clk,
  input  logic         rst,
  uart_rx_os_if.slave  bus
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e               state_q;
  logic                 rxd_meta_q, rxd_s_q;
  logic [TickW-1:0]     tick_cnt_q;
  logic [BitW-1:0]      bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rxdata_q;
  logic                 rx_valid_q, frame_err_q, overrun_q;

  // Two-flop synchroniser; idle-high reset value avoids a false start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= bus.rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rxdata_q    <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (bus.rx_ack) begin
        rx_valid_q <= 1'b0;
        overrun_q  <= 1'b0;
      end
      if (bus.rx_int) begin
        unique case (state_q)
          StIdle: begin
            if (!rxd_s_q) begin
              state_q    <= StStart;
              tick_cnt_q <= '0;
            end
          end
          StStart: begin
            if (tick_cnt_q == TickHalf) begin
              if (rxd_s_q) begin
                state_q <= StIdle;
              end else begin
                state_q    <= StData;
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          StData: begin
            if (tick_cnt_q == TickLast) begin
              shift_q    <= {rxd_s_q, shift_q[DATA_BITS-1:1]};
              tick_cnt_q <= '0;
              if (bit_cnt_q == BitLast) begin
                state_q <= StStop;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          StStop: begin
            if (tick_cnt_q == TickLast) begin
              tick_cnt_q <= '0;
              if (rxd_s_q) begin
                rxdata_q    <= shift_q;
                rx_valid_q  <= 1'b1;
                frame_err_q <= 1'b0;
                // A simultaneous ack consumed the old byte, so no overrun then.
                if (rx_valid_q && !bus.rx_ack) overrun_q <= 1'b1;
                state_q <= StIdle;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= StBreak;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          StBreak: begin
            if (rxd_s_q) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.rxdata    = rxdata_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: OVERSAMPLE=16, DATA_BITS=8, tick every 4th clk.
module tb_uart_rx_os;

  logic       clk;
  logic       rst;
  logic [1:0] div;
  int         vectors;
  int         miscompares;

  // Snapshots taken one clk before and right after the stop-sample edge.
  logic       pre_valid;
  logic       post_valid, post_ferr, post_ovr;
  logic [7:0] post_data;

  uart_rx_os_if #(.DATA_BITS(8)) bus ();

  uart_rx_os #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial div = 2'd0;
  always @(posedge clk) div <= div + 2'd1;
  assign bus.rx_int = (div == 2'd3);

  // Frame starts just after a tick edge T; the stop sample lands on edge T+612.
  task automatic send_frame(input logic [7:0] data, input logic stop, input bit ack_at_stop);
    @(posedge clk); #1;
    while (div != 2'd0) begin
      @(posedge clk); #1;
    end
    bus.rxd = 1'b0;
    repeat (64) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      bus.rxd = data[i];
      repeat (64) @(posedge clk);
      #1;
    end
    bus.rxd = stop;
    repeat (35) @(posedge clk);
    #1;
    pre_valid = bus.rx_valid;
    if (ack_at_stop) bus.rx_ack = 1'b1;
    @(posedge clk); #1;
    bus.rx_ack = 1'b0;
    post_valid = bus.rx_valid;
    post_ferr  = bus.frame_err;
    post_ovr   = bus.overrun;
    post_data  = bus.rxdata;
    repeat (28) @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    @(posedge clk); #1;
    bus.rx_ack = 1'b1;
    @(posedge clk); #1;
    bus.rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rxd = 1'b1;
    bus.rx_ack = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (bus.rx_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid: got %b want 0", bus.rx_valid);
    end
    vectors++;
    if (bus.rxdata !== 8'h00) begin
      miscompares++; $display("FAIL reset_rxdata: got %h want 00", bus.rxdata);
    end
    vectors++;
    if ({bus.frame_err, bus.overrun} !== 2'b00) begin
      miscompares++; $display("FAIL reset_flags: got %b want 00", {bus.frame_err, bus.overrun});
    end
    rst = 1'b0;
    repeat (16) @(posedge clk);
  endtask

  task automatic test_good_frame();
    send_frame(8'hA5, 1'b1, 1'b0);
    vectors++;
    if (pre_valid !== 1'b0) begin
      miscompares++; $display("FAIL a5_pre_valid: got %b want 0", pre_valid);
    end
    vectors++;
    if ({post_valid, post_data} !== {1'b1, 8'hA5}) begin
      miscompares++;
      $display("FAIL a5_stop_edge: got valid=%b data=%h want valid=1 data=a5", post_valid, post_data);
    end
    vectors++;
    if ({post_ferr, post_ovr} !== 2'b00) begin
      miscompares++; $display("FAIL a5_flags: got %b want 00", {post_ferr, post_ovr});
    end
    ack_pulse();
    vectors++;
    if (bus.rx_valid !== 1'b0) begin
      miscompares++; $display("FAIL a5_ack: got valid=%b want 0", bus.rx_valid);
    end
  endtask

  task automatic test_glitch();
    @(posedge clk); #1;
    while (div != 2'd0) begin
      @(posedge clk); #1;
    end
    bus.rxd = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    bus.rxd = 1'b1;
    repeat (128) @(posedge clk);
    #1;
    vectors++;
    if ({bus.rx_valid, bus.frame_err} !== 2'b00) begin
      miscompares++;
      $display("FAIL glitch_reject: got valid/ferr=%b want 00", {bus.rx_valid, bus.frame_err});
    end
    send_frame(8'h3C, 1'b1, 1'b0);
    vectors++;
    if ({post_valid, post_data, post_ferr} !== {1'b1, 8'h3C, 1'b0}) begin
      miscompares++;
      $display("FAIL glitch_next_frame: got valid=%b data=%h ferr=%b want 1 3c 0",
               post_valid, post_data, post_ferr);
    end
    ack_pulse();
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0, 1'b0);
    vectors++;
    if ({post_ferr, post_valid, post_data} !== {1'b1, 1'b0, 8'h3C}) begin
      miscompares++;
      $display("FAIL ferr_stop_edge: got ferr=%b valid=%b data=%h want 1 0 3c",
               post_ferr, post_valid, post_data);
    end
    repeat (192) @(posedge clk);
    #1;
    vectors++;
    if ({bus.frame_err, bus.rx_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL ferr_break_hold: got ferr/valid=%b want 10", {bus.frame_err, bus.rx_valid});
    end
    bus.rxd = 1'b1;
    repeat (64) @(posedge clk);
    send_frame(8'h81, 1'b1, 1'b0);
    vectors++;
    if ({post_valid, post_data, post_ferr} !== {1'b1, 8'h81, 1'b0}) begin
      miscompares++;
      $display("FAIL ferr_recover: got valid=%b data=%h ferr=%b want 1 81 0",
               post_valid, post_data, post_ferr);
    end
    ack_pulse();
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, 1'b0);
    vectors++;
    if ({post_valid, post_ovr} !== 2'b10) begin
      miscompares++; $display("FAIL ovr_first: got valid/ovr=%b want 10", {post_valid, post_ovr});
    end
    send_frame(8'h22, 1'b1, 1'b0);
    vectors++;
    if ({post_valid, post_data, post_ovr} !== {1'b1, 8'h22, 1'b1}) begin
      miscompares++;
      $display("FAIL ovr_second: got valid=%b data=%h ovr=%b want 1 22 1",
               post_valid, post_data, post_ovr);
    end
    ack_pulse();
    vectors++;
    if ({bus.rx_valid, bus.overrun} !== 2'b00) begin
      miscompares++;
      $display("FAIL ovr_ack: got valid/ovr=%b want 00", {bus.rx_valid, bus.overrun});
    end
    ack_pulse();
    vectors++;
    if ({bus.rxdata, bus.frame_err, bus.rx_valid} !== {8'h22, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL idle_ack: got data=%h ferr=%b valid=%b want 22 0 0",
               bus.rxdata, bus.frame_err, bus.rx_valid);
    end
  endtask

  task automatic test_back_to_back_ack();
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b1);
    vectors++;
    if (pre_valid !== 1'b1) begin
      miscompares++; $display("FAIL ack_edge_pending: got valid=%b want 1", pre_valid);
    end
    vectors++;
    if ({post_valid, post_data, post_ovr} !== {1'b1, 8'h55, 1'b0}) begin
      miscompares++;
      $display("FAIL ack_edge_load: got valid=%b data=%h ovr=%b want 1 55 0",
               post_valid, post_data, post_ovr);
    end
  endtask

  task automatic test_reset_midframe();
    @(posedge clk); #1;
    while (div != 2'd0) begin
      @(posedge clk); #1;
    end
    bus.rxd = 1'b0;
    repeat (64) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      bus.rxd = 1'b0;
      repeat (64) @(posedge clk);
      #1;
    end
    bus.rxd = 1'b1;
    repeat (32) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    vectors++;
    if ({bus.rx_valid, bus.rxdata, bus.frame_err, bus.overrun} !== 11'd0) begin
      miscompares++;
      $display("FAIL rst_async: got valid=%b data=%h ferr=%b ovr=%b want all 0",
               bus.rx_valid, bus.rxdata, bus.frame_err, bus.overrun);
    end
    repeat (8) @(posedge clk);
    #1;
    vectors++;
    if ({bus.rx_valid, bus.rxdata, bus.frame_err, bus.overrun} !== 11'd0) begin
      miscompares++;
      $display("FAIL rst_hold: got valid=%b data=%h ferr=%b ovr=%b want all 0",
               bus.rx_valid, bus.rxdata, bus.frame_err, bus.overrun);
    end
    rst = 1'b0;
    repeat (24 + 4 * 64) @(posedge clk);
    #1;
    vectors++;
    if (bus.rx_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_no_stale_byte: got valid=%b want 0", bus.rx_valid);
    end
    repeat (32) @(posedge clk);
    send_frame(8'h0F, 1'b1, 1'b0);
    vectors++;
    if ({post_valid, post_data, post_ferr, post_ovr} !== {1'b1, 8'h0F, 2'b00}) begin
      miscompares++;
      $display("FAIL rst_next_frame: got valid=%b data=%h ferr=%b ovr=%b want 1 0f 0 0",
               post_valid, post_data, post_ferr, post_ovr);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_good_frame();
    test_glitch();
    test_framing();
    test_overrun();
    test_back_to_back_ack();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
